// File: rtl/change_dispenser.sv
// Greedy change payout: snapshots amount and note inventory on start, plans one note per
// cycle, then emits the planned notes largest-first over a valid/ready handshake.
module change_dispenser #(
   parameter int unsigned AMOUNT_W = 16,
   parameter int unsigned COUNT_W  = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [AMOUNT_W-1:0] change_amount,
   input  logic [COUNT_W-1:0]  avail_500,
   input  logic [COUNT_W-1:0]  avail_1000,
   input  logic [COUNT_W-1:0]  avail_2000,
   input  logic [COUNT_W-1:0]  avail_5000,
   input  logic                note_ready,
   output logic                note_valid,
   output logic [3:0]          note_type,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [AMOUNT_W-1:0] dispensed
);

   typedef enum logic [1:0] {StIdle, StPlan, StDispense, StDone} state_e;

   state_e               state_q;
   logic [AMOUNT_W-1:0]  remaining_q;
   logic [COUNT_W-1:0]   avail_q [4];
   logic [COUNT_W-1:0]   plan_q  [4];

   logic [COUNT_W-1:0]   plan_nxt [4];
   logic [3:0]           plan_nz;
   logic [3:0]           nxt_nz;
   logic [3:0]           top_type;
   logic [3:0]           nxt_type;
   logic [3:0]           pick;
   logic [AMOUNT_W-1:0]  pick_val;
   logic                 found;
   logic                 fire;
   logic [AMOUNT_W-1:0]  fire_val;

   // Index 0..3 maps to 500, 1000, 2000, 5000, matching the one-hot bit positions.
   function automatic logic [AMOUNT_W-1:0] denom(input int i);
      case (i)
         0:       denom = AMOUNT_W'(500);
         1:       denom = AMOUNT_W'(1000);
         2:       denom = AMOUNT_W'(2000);
         default: denom = AMOUNT_W'(5000);
      endcase
   endfunction

   function automatic logic [3:0] pick_top(input logic [3:0] nz);
      if (nz[3])      pick_top = 4'b1000;
      else if (nz[2]) pick_top = 4'b0100;
      else if (nz[1]) pick_top = 4'b0010;
      else if (nz[0]) pick_top = 4'b0001;
      else            pick_top = 4'b0000;
   endfunction

   assign busy = (state_q != StIdle);

   always_comb begin
      fire     = note_valid && note_ready;
      fire_val = '0;
      pick     = 4'b0000;
      pick_val = '0;
      found    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         plan_nz[i]  = (plan_q[i] != '0);
         plan_nxt[i] = (fire && note_type[i]) ? plan_q[i] - COUNT_W'(1) : plan_q[i];
         nxt_nz[i]   = (plan_nxt[i] != '0);
         if (note_type[i]) fire_val = denom(i);
      end
      top_type = pick_top(plan_nz);
      nxt_type = pick_top(nxt_nz);
      // Largest note that still fits the remainder and the snapshotted inventory.
      for (int i = 3; i >= 0; i--) begin
         if (!found && denom(i) <= remaining_q && plan_q[i] < avail_q[i]) begin
            found    = 1'b1;
            pick[i]  = 1'b1;
            pick_val = denom(i);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         for (int i = 0; i < 4; i++) begin
            avail_q[i] <= '0;
            plan_q[i]  <= '0;
         end
         note_valid <= 1'b0;
         note_type  <= 4'b0000;
         done       <= 1'b0;
         error      <= 1'b0;
         dispensed  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  remaining_q <= change_amount;
                  avail_q[0]  <= avail_500;
                  avail_q[1]  <= avail_1000;
                  avail_q[2]  <= avail_2000;
                  avail_q[3]  <= avail_5000;
                  for (int i = 0; i < 4; i++) plan_q[i] <= '0;
                  dispensed   <= '0;
                  error       <= 1'b0;
                  state_q     <= StPlan;
               end
            end
            StPlan: begin
               if (remaining_q == '0) begin
                  state_q    <= StDispense;
                  note_valid <= |plan_nz;
                  note_type  <= top_type;
               end else if (found) begin
                  for (int i = 0; i < 4; i++) begin
                     if (pick[i]) plan_q[i] <= plan_q[i] + COUNT_W'(1);
                  end
                  remaining_q <= remaining_q - pick_val;
               end else begin
                  error   <= 1'b1;
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDispense: begin
               if (fire) begin
                  for (int i = 0; i < 4; i++) plan_q[i] <= plan_nxt[i];
                  dispensed <= dispensed + fire_val;
                  if (nxt_nz == 4'b0000) begin
                     note_valid <= 1'b0;
                     note_type  <= 4'b0000;
                     done       <= 1'b1;
                     state_q    <= StDone;
                  end else begin
                     note_type <= nxt_type;
                  end
               end else if (!note_valid) begin
                  // Zero-note request: nothing to hand over.
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed checks of change_dispenser against a count-based greedy model.
module tb_change_dispenser;
   localparam int AW = 16;
   localparam int CW = 8;

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] change_amount;
   logic [CW-1:0] avail_500, avail_1000, avail_2000, avail_5000;
   logic          note_ready;
   logic          note_valid;
   logic [3:0]    note_type;
   logic          busy, done, error;
   logic [AW-1:0] dispensed;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_q [$];
   logic [3:0] got_q [$];
   int         exp_n;
   bit         exp_err;

   change_dispenser #(.AMOUNT_W(AW), .COUNT_W(CW)) dut (
      .clock(clock), .reset(reset), .start(start), .change_amount(change_amount),
      .avail_500(avail_500), .avail_1000(avail_1000), .avail_2000(avail_2000),
      .avail_5000(avail_5000), .note_ready(note_ready), .note_valid(note_valid),
      .note_type(note_type), .busy(busy), .done(done), .error(error), .dispensed(dispensed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Greedy payout as whole counts per denomination, largest first.
   task automatic model(input int amount, input int a0, input int a1, input int a2,
                        input int a3);
      int val [4];
      int av  [4];
      int rem;
      int take;
      val = '{500, 1000, 2000, 5000};
      av  = '{a0, a1, a2, a3};
      exp_q.delete();
      rem   = amount;
      exp_n = 0;
      for (int i = 3; i >= 0; i--) begin
         take = rem / val[i];
         if (take > av[i]) take = av[i];
         rem   -= take * val[i];
         exp_n += take;
         for (int j = 0; j < take; j++) exp_q.push_back(4'(1 << i));
      end
      exp_err = (rem != 0);
      if (exp_err) exp_q.delete();
   endtask

   // mode 0: ready always high; 1: random ready; 2: stall first note 3 cycles + stray starts
   task automatic run_req(input string tag, input int amount, input int a0, input int a1,
                          input int a2, input int a3, input int mode);
      int first_valid;
      int done_c;
      int stalls;
      bit prev_stall;
      logic [3:0] prev_type;
      model(amount, a0, a1, a2, a3);
      got_q.delete();
      @(negedge clock);
      change_amount = AW'(amount);
      avail_500 = CW'(a0); avail_1000 = CW'(a1); avail_2000 = CW'(a2); avail_5000 = CW'(a3);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      change_amount = AW'($urandom);
      avail_500 = CW'($urandom); avail_1000 = CW'($urandom);
      avail_2000 = CW'($urandom); avail_5000 = CW'($urandom);
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      first_valid = -1;
      done_c      = -1;
      stalls      = 0;
      prev_stall  = 1'b0;
      prev_type   = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         start = 1'b0;
         case (mode)
            0: note_ready = 1'b1;
            1: note_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (note_valid && got_q.size() == 0 && stalls < 3) begin
                  note_ready    = 1'b0;
                  stalls++;
                  start         = 1'b1;
                  change_amount = AW'(500);
               end else begin
                  note_ready = 1'b1;
               end
            end
         endcase
         if (prev_stall) check({tag, " type_hold"}, 32'(note_type), 32'(prev_type));
         if (note_valid && first_valid < 0) first_valid = c;
         if (note_valid && note_ready) got_q.push_back(note_type);
         prev_stall = note_valid && !note_ready;
         prev_type  = note_type;
         if (done) begin
            done_c = c;
            break;
         end
      end
      start = 1'b0;
      check({tag, " done_seen"}, 32'(done_c >= 0), 32'd1);
      check({tag, " busy_in_done"}, 32'(busy), 32'd1);
      check({tag, " error"}, 32'(error), 32'(exp_err));
      check({tag, " dispensed"}, 32'(dispensed), exp_err ? 32'd0 : 32'(amount));
      check({tag, " note_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, " note_seq"}, 32'(got_q[i]), 32'(exp_q[i]));
      if (exp_err) check({tag, " fail_plan_len"}, 32'(done_c), 32'(exp_n + 1));
      else if (exp_n > 0) check({tag, " plan_len"}, 32'(first_valid), 32'(exp_n + 1));
      else check({tag, " zero_done"}, 32'(done_c), 32'd2);
      if (mode == 0 && !exp_err && exp_n > 0)
         check({tag, " back_to_back"}, 32'(done_c), 32'(2 * exp_n + 1));
      if (mode == 2) check({tag, " stalls"}, 32'(stalls), 32'd3);
      @(negedge clock);
      note_ready = 1'b0;
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " idle_done"}, 32'(done), 32'd0);
      check({tag, " error_held"}, 32'(error), 32'(exp_err));
   endtask

   initial begin
      int seen;
      int amt;
      reset = 1'b0; start = 1'b0; change_amount = '0; note_ready = 1'b0;
      avail_500 = '0; avail_1000 = '0; avail_2000 = '0; avail_5000 = '0;
      #12;
      check("rst note_valid", 32'(note_valid), 32'd0);
      check("rst note_type", 32'(note_type), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst error", 32'(error), 32'd0);
      check("rst dispensed", 32'(dispensed), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run_req("r8500", 8500, 1, 1, 1, 1, 0);
      run_req("r4000", 4000, 4, 0, 1, 3, 0);
      run_req("r6000", 6000, 0, 0, 3, 1, 0);
      run_req("r700", 700, 9, 9, 9, 9, 0);
      run_req("r0", 0, 3, 3, 3, 3, 0);
      run_req("bp3000", 3000, 9, 9, 9, 9, 2);

      // Reset while a note is on offer must drop everything without a clock edge.
      @(negedge clock);
      change_amount = AW'(8500);
      avail_500 = 8'd1; avail_1000 = 8'd1; avail_2000 = 8'd1; avail_5000 = 8'd1;
      note_ready = 1'b0;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (note_valid) begin
            seen = 1;
            break;
         end
      end
      check("rstmid valid_before", 32'(seen), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rstmid note_valid", 32'(note_valid), 32'd0);
      check("rstmid busy", 32'(busy), 32'd0);
      check("rstmid dispensed", 32'(dispensed), 32'd0);
      check("rstmid note_type", 32'(note_type), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      run_req("after_rst", 500, 1, 0, 0, 0, 0);

      for (int k = 0; k < 25; k++) begin
         amt = $urandom_range(0, 40) * 500;
         if ($urandom_range(0, 4) == 0) amt += $urandom_range(1, 499);
         run_req("rand", amt, $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
